aes128_decrypt_iter: RTL

Iterative AES-128 inverse cipher (FIPS-197 InvCipher), the decrypt-side counterpart of the AES128 encryptor. It accepts a 128-bit ciphertext and cipher key as four 32-bit words each, expands the key forward to round key 10, then runs 10 inverse rounds at one round per clock, regenerating round keys on the fly with the inverse key schedule. Valid/ready handshakes on input and output let it sit between the DPR static region's data mover and the reconfigurable AES partition.

---
 rtl/aes_pkg.sv | 83 ++++++++
 rtl/forward_substitution_box.sv | 19 +
 rtl/inverse_substitution_box.sv | 17 +
 rtl/aes128_decrypt_iter.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES helpers for the iterative inverse cipher: FSM states, Rcon, GF(2^8) math,
// and the byte-order convention (byte k of a block sits at bits [127-8k -: 8], column c at [127-32c -: 32]).
package aes_pkg;

    typedef enum logic [1:0] {IDLE, KEYEXP, ROUND, DONE} state_t;

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as b^254 (b^2 * b^4 * ... * b^128); maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] b);
        logic [7:0] sq;
        logic [7:0] r;
        sq = b;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gmul(sq, sq);
            r  = gmul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
                gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) o[127-32*c -: 32] = inv_mix_column(s[127-32*c -: 32]);
        return o;
    endfunction

    // Row r is rotated right by r columns: out[r][c] = in[r][(c - r) mod 4].
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
            end
        end
        return o;
    endfunction

endpackage

// File: rtl/forward_substitution_box.sv
// AES forward S-box: GF(2^8) inverse followed by the FIPS-197 affine transform.
module forward_substitution_box
    import aes_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    logic [7:0] w_inv;

    assign w_inv  = gf_inv(i_byte);
    assign o_byte = w_inv
                  ^ {w_inv[6:0], w_inv[7]}
                  ^ {w_inv[5:0], w_inv[7:6]}
                  ^ {w_inv[4:0], w_inv[7:5]}
                  ^ {w_inv[3:0], w_inv[7:4]}
                  ^ 8'h63;

endmodule

// File: rtl/inverse_substitution_box.sv
// AES inverse S-box: inverse affine transform followed by the GF(2^8) inverse.
module inverse_substitution_box
    import aes_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    logic [7:0] w_aff;

    assign w_aff  = {i_byte[6:0], i_byte[7]}
                  ^ {i_byte[4:0], i_byte[7:5]}
                  ^ {i_byte[1:0], i_byte[7:2]}
                  ^ 8'h05;
    assign o_byte = gf_inv(w_aff);

endmodule

// File: rtl/aes128_decrypt_iter.sv
// Iterative AES-128 inverse cipher: 10 forward key-expansion clocks, then 10 inverse rounds
// with the round key regenerated backwards each clock. One job in flight, valid/ready on both sides.
module aes128_decrypt_iter
    import aes_pkg::*;
#(
    parameter int NR        = 10,
    parameter int KEY_WORDS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] inp_data_0,
    input  logic [31:0] inp_data_1,
    input  logic [31:0] inp_data_2,
    input  logic [31:0] inp_data_3,
    input  logic [31:0] inp_key_0,
    input  logic [31:0] inp_key_1,
    input  logic [31:0] inp_key_2,
    input  logic [31:0] inp_key_3,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data_0,
    output logic [31:0] out_data_1,
    output logic [31:0] out_data_2,
    output logic [31:0] out_data_3
);

    localparam int KW = 32 * KEY_WORDS;

    state_t         r_fsm;
    state_t         w_fsm_nxt;
    logic [127:0]   r_state;
    logic [KW-1:0]  r_key;
    logic [3:0]     r_rcnt;
    logic [127:0]   r_out;
    logic           r_out_valid;

    logic [31:0]    w_kw0, w_kw1, w_kw2, w_kw3;
    logic [31:0]    w_inv_w1, w_inv_w2, w_inv_w3;
    logic [31:0]    w_sb_src, w_rot, w_sb_out, w_temp, w_new0;
    logic [7:0]     w_rcon;
    logic [127:0]   w_key_fwd, w_key_inv;
    logic [127:0]   w_isr, w_isb, w_ark, w_round;

    assign w_kw0 = r_key[127:96];
    assign w_kw1 = r_key[95:64];
    assign w_kw2 = r_key[63:32];
    assign w_kw3 = r_key[31:0];

    assign w_inv_w3 = w_kw3 ^ w_kw2;
    assign w_inv_w2 = w_kw2 ^ w_kw1;
    assign w_inv_w1 = w_kw1 ^ w_kw0;

    // The four forward S-boxes serve both schedule directions; the FSM state picks the source word.
    assign w_sb_src = (r_fsm == KEYEXP) ? w_kw3 : w_inv_w3;
    assign w_rot    = {w_sb_src[23:0], w_sb_src[31:24]};
    assign w_rcon   = rcon((r_fsm == KEYEXP) ? r_rcnt : r_rcnt + 4'd1);

    for (genvar g = 0; g < 4; g++) begin : g_fsb
        forward_substitution_box u_fsb (
            .i_byte (w_rot[31-8*g -: 8]),
            .o_byte (w_sb_out[31-8*g -: 8])
        );
    end

    assign w_temp    = w_sb_out ^ {w_rcon, 24'h000000};
    assign w_new0    = w_kw0 ^ w_temp;
    assign w_key_fwd = {w_new0, w_kw1 ^ w_new0, w_kw2 ^ w_kw1 ^ w_new0, w_kw3 ^ w_kw2 ^ w_kw1 ^ w_new0};
    assign w_key_inv = {w_new0, w_inv_w1, w_inv_w2, w_inv_w3};

    assign w_isr = inv_shift_rows(r_state);

    for (genvar g = 0; g < 16; g++) begin : g_isb
        inverse_substitution_box u_isb (
            .i_byte (w_isr[127-8*g -: 8]),
            .o_byte (w_isb[127-8*g -: 8])
        );
    end

    assign w_ark   = w_isb ^ w_key_inv;
    assign w_round = (r_rcnt == 4'd0) ? w_ark : inv_mix_columns(w_ark);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_fsm <= IDLE;
        else       r_fsm <= w_fsm_nxt;
    end

    always_comb begin
        w_fsm_nxt = r_fsm;
        case (r_fsm)
            IDLE:    if (in_valid)                 w_fsm_nxt = KEYEXP;
            KEYEXP:  if (r_rcnt == 4'(NR))         w_fsm_nxt = ROUND;
            ROUND:   if (r_rcnt == 4'd0)           w_fsm_nxt = DONE;
            DONE:    if (r_out_valid && out_ready) w_fsm_nxt = IDLE;
            default:                               w_fsm_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= '0;
            r_key       <= '0;
            r_rcnt      <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_fsm)
                IDLE: begin
                    if (in_valid) begin
                        r_state <= {inp_data_3, inp_data_2, inp_data_1, inp_data_0};
                        r_key   <= {inp_key_3, inp_key_2, inp_key_1, inp_key_0};
                        r_rcnt  <= 4'd1;
                    end
                end
                KEYEXP: begin
                    r_key <= w_key_fwd;
                    if (r_rcnt == 4'(NR)) begin
                        r_state <= r_state ^ w_key_fwd;
                        r_rcnt  <= 4'(NR - 1);
                    end else begin
                        r_rcnt  <= r_rcnt + 4'd1;
                    end
                end
                ROUND: begin
                    r_state <= w_round;
                    r_key   <= w_key_inv;
                    if (r_rcnt == 4'd0) begin
                        r_out       <= w_round;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_rcnt      <= r_rcnt - 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) r_out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign in_ready   = (r_fsm == IDLE);
    assign out_valid  = r_out_valid;
    assign out_data_3 = r_out[127:96];
    assign out_data_2 = r_out[95:64];
    assign out_data_1 = r_out[63:32];
    assign out_data_0 = r_out[31:0];

endmodule
